// File: rtl/tpu_pe_pipe.sv
// Pipelined systolic MAC processing element: forwards A/B east/south, multiplies in
// stage 1 and accumulates (signed/unsigned, saturating or wrapping) in stage 2.
module tpu_pe_pipe #(
  parameter int unsigned BITS_AB  = 8,
  parameter int unsigned BITS_C   = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [BITS_AB-1:0]  Ain,
  input  logic [BITS_AB-1:0]  Bin,
  input  logic                vin,
  input  logic                clr_in,
  input  logic                sgn_in,
  input  logic                WrEn,
  input  logic [BITS_C-1:0]   Cin,
  output logic [BITS_AB-1:0]  Aout,
  output logic [BITS_AB-1:0]  Bout,
  output logic                vout,
  output logic                clr_out,
  output logic                sgn_out,
  output logic [BITS_C-1:0]   Cout,
  output logic                ovf
);

  localparam int unsigned PW = 2 * BITS_AB + 1;
  localparam int unsigned SW = BITS_C + 2;

  localparam logic signed [SW-1:0] MAX_S = {3'b000, {(BITS_C-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {3'b111, {(BITS_C-1){1'b0}}};
  localparam logic signed [SW-1:0] MAX_U = {2'b00, {BITS_C{1'b1}}};

  logic [BITS_AB-1:0] a_q, b_q;
  logic               v_q, clr_q, sgn_q;
  logic               p_v_q, p_clr_q, p_sgn_q;
  logic [PW-1:0]      p_prod_q;
  logic [BITS_C-1:0]  c_q, c_d;
  logic               ovf_q, ovf_d;

  logic signed [PW-1:0] a_ext, b_ext, prod_c;
  logic signed [SW-1:0] base_x, prod_x, sum_c;
  logic                 too_hi, too_lo;

  // Stage-1 operand extension and product; PW bits hold any signed or unsigned product.
  always_comb begin
    a_ext  = sgn_in ? {{(PW-BITS_AB){Ain[BITS_AB-1]}}, Ain} : {{(PW-BITS_AB){1'b0}}, Ain};
    b_ext  = sgn_in ? {{(PW-BITS_AB){Bin[BITS_AB-1]}}, Bin} : {{(PW-BITS_AB){1'b0}}, Bin};
    prod_c = a_ext * b_ext;
  end

  // Unsigned products never set the top product bit, so sign extension suits both modes.
  always_comb begin
    base_x = '0;
    if (!p_clr_q) begin
      base_x = p_sgn_q ? {{2{c_q[BITS_C-1]}}, c_q} : {2'b00, c_q};
    end
    prod_x = {{(SW-PW){p_prod_q[PW-1]}}, p_prod_q};
    sum_c  = base_x + prod_x;
    too_hi = p_sgn_q ? (sum_c > MAX_S) : (sum_c > MAX_U);
    too_lo = p_sgn_q && (sum_c < MIN_S);
  end

  // Stage-2 accumulate; a load from Cin overrides any accumulate in the same cycle.
  always_comb begin
    c_d   = c_q;
    ovf_d = ovf_q;
    if (en && p_v_q) begin
      c_d   = sum_c[BITS_C-1:0];
      ovf_d = p_clr_q ? 1'b0 : ovf_q;
      if (too_hi || too_lo) begin
        ovf_d = 1'b1;
        if (SATURATE) begin
          if (too_hi) begin
            c_d = p_sgn_q ? {1'b0, {(BITS_C-1){1'b1}}} : {BITS_C{1'b1}};
          end else begin
            c_d = {1'b1, {(BITS_C-1){1'b0}}};
          end
        end
      end
    end
    if (WrEn) begin
      c_d   = Cin;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      v_q      <= 1'b0;
      clr_q    <= 1'b0;
      sgn_q    <= 1'b0;
      p_v_q    <= 1'b0;
      p_clr_q  <= 1'b0;
      p_sgn_q  <= 1'b0;
      p_prod_q <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (en) begin
        a_q      <= Ain;
        b_q      <= Bin;
        v_q      <= vin;
        clr_q    <= clr_in;
        sgn_q    <= sgn_in;
        p_v_q    <= vin;
        p_clr_q  <= clr_in;
        p_sgn_q  <= sgn_in;
        p_prod_q <= prod_c;
      end
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign Aout    = a_q;
  assign Bout    = b_q;
  assign vout    = v_q;
  assign clr_out = clr_q;
  assign sgn_out = sgn_q;
  assign Cout    = c_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_tpu_pe_pipe.sv
// Scoreboard bench for tpu_pe_pipe: a saturating and a wrapping instance share stimulus;
// expectations are queued per cycle and a separate monitor compares them.
module tb_tpu_pe_pipe;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic        vin = 1'b0, clr_in = 1'b0, sgn_in = 1'b0, WrEn = 1'b0;
  logic [7:0]  Ain = '0, Bin = '0;
  logic [15:0] Cin = '0;

  logic [7:0]  a_s, b_s, a_w, b_w;
  logic        v_s, clr_s, sg_s, o_s, v_w, clr_w, sg_w, o_w;
  logic [15:0] c_s, c_w;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  event rst_chk_ev;

  tpu_pe_pipe #(.BITS_AB(8), .BITS_C(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .Ain(Ain), .Bin(Bin), .vin(vin),
    .clr_in(clr_in), .sgn_in(sgn_in), .WrEn(WrEn), .Cin(Cin),
    .Aout(a_s), .Bout(b_s), .vout(v_s), .clr_out(clr_s), .sgn_out(sg_s),
    .Cout(c_s), .ovf(o_s));

  tpu_pe_pipe #(.BITS_AB(8), .BITS_C(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .Ain(Ain), .Bin(Bin), .vin(vin),
    .clr_in(clr_in), .sgn_in(sgn_in), .WrEn(WrEn), .Cin(Cin),
    .Aout(a_w), .Bout(b_w), .vout(v_w), .clr_out(clr_w), .sgn_out(sg_w),
    .Cout(c_w), .ovf(o_w));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(int kind);
    case (kind)
      0:       return c_s;
      1:       return 16'(o_s);
      2:       return c_w;
      3:       return 16'(o_w);
      4:       return 16'(a_s);
      5:       return 16'(v_s);
      6:       return 16'(b_s);
      7:       return 16'(clr_s);
      default: return 16'(sg_s);
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0:       return "cout_sat";
      1:       return "ovf_sat";
      2:       return "cout_wrap";
      3:       return "ovf_wrap";
      4:       return "aout";
      5:       return "vout";
      6:       return "bout";
      7:       return "clr_out";
      default: return "sgn_out";
    endcase
  endfunction

  // Monitor: compares every expectation tagged for the current cycle.
  always begin
    exp_t keep[$];
    @(negedge clk or rst_chk_ev);
    keep = {};
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc == cyc) begin
        checks++;
        if (actual(exp_q[i].kind) !== exp_q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%h expected=%h", kname(exp_q[i].kind), cyc,
                   actual(exp_q[i].kind), exp_q[i].val);
        end
      end else if (exp_q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d expectation never sampled", kname(exp_q[i].kind), exp_q[i].cyc);
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int c, int k, logic [15:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expc(int c, logic [15:0] cs, logic os, logic [15:0] cw, logic ow);
    push(c, 0, cs);
    push(c, 1, 16'(os));
    push(c, 2, cw);
    push(c, 3, 16'(ow));
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b, logic clr, logic sgn);
    Ain = a; Bin = b; vin = 1'b1; clr_in = clr; sgn_in = sgn;
    tick();
    push(cyc, 4, 16'(a));
    push(cyc, 6, 16'(b));
    push(cyc, 5, 16'd1);
    push(cyc, 7, 16'(clr));
    push(cyc, 8, 16'(sgn));
  endtask

  task automatic idle(int n);
    vin = 1'b0; clr_in = 1'b0; Ain = '0; Bin = '0;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    expc(1, 16'd0, 1'b0, 16'd0, 1'b0);
    for (int k = 4; k <= 8; k++) push(1, k, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // Signed streaming
    send(8'd3, 8'd4, 1'b1, 1'b1);   expc(cyc + 1, 16'd12, 1'b0, 16'd12, 1'b0);
    send(8'hFE, 8'd5, 1'b0, 1'b1);  expc(cyc + 1, 16'd2, 1'b0, 16'd2, 1'b0);
    send(8'd7, 8'hFF, 1'b0, 1'b1);  expc(cyc + 1, 16'hFFFB, 1'b0, 16'hFFFB, 1'b0);
    idle(3);

    // Signed saturation / wrap at both limits
    send(8'd127, 8'd127, 1'b1, 1'b1); expc(cyc + 1, 16'd16129, 1'b0, 16'd16129, 1'b0);
    send(8'd127, 8'd127, 1'b0, 1'b1); expc(cyc + 1, 16'd32258, 1'b0, 16'd32258, 1'b0);
    send(8'd127, 8'd127, 1'b0, 1'b1); expc(cyc + 1, 16'h7FFF, 1'b1, 16'hBD03, 1'b1);
    send(8'h80, 8'd127, 1'b1, 1'b1);  expc(cyc + 1, 16'hC080, 1'b0, 16'hC080, 1'b0);
    send(8'h80, 8'd127, 1'b0, 1'b1);  expc(cyc + 1, 16'h8100, 1'b0, 16'h8100, 1'b0);
    send(8'h80, 8'd127, 1'b0, 1'b1);  expc(cyc + 1, 16'h8000, 1'b1, 16'h4180, 1'b1);
    idle(3);

    // Unsigned overflow
    send(8'd255, 8'd255, 1'b1, 1'b0); expc(cyc + 1, 16'hFE01, 1'b0, 16'hFE01, 1'b0);
    send(8'd255, 8'd255, 1'b0, 1'b0); expc(cyc + 1, 16'hFFFF, 1'b1, 16'hFC02, 1'b1);
    idle(3);

    // Load while stalled also clears the sticky flag
    en = 1'b0; WrEn = 1'b1; Cin = 16'h1234;
    tick();
    expc(cyc, 16'h1234, 1'b0, 16'h1234, 1'b0);
    WrEn = 1'b0; en = 1'b1;
    idle(2);

    // Stall after the third pair; inputs during the stall must not leak in
    send(8'd2, 8'd3, 1'b1, 1'b1); expc(cyc + 1, 16'd6, 1'b0, 16'd6, 1'b0);
    send(8'd2, 8'd3, 1'b0, 1'b1); expc(cyc + 1, 16'd12, 1'b0, 16'd12, 1'b0);
    send(8'd2, 8'd3, 1'b0, 1'b1);
    en = 1'b0; Ain = 8'd9; Bin = 8'd9; vin = 1'b0; clr_in = 1'b1;
    repeat (2) begin
      tick();
      expc(cyc, 16'd12, 1'b0, 16'd12, 1'b0);
      push(cyc, 4, 16'd2);
      push(cyc, 5, 16'd1);
    end
    en = 1'b1;
    send(8'd2, 8'd3, 1'b0, 1'b1); expc(cyc, 16'd18, 1'b0, 16'd18, 1'b0);
    expc(cyc + 1, 16'd24, 1'b0, 16'd24, 1'b0);
    idle(3);

    // Load collides with a stage-2 accumulate
    send(8'd5, 8'd5, 1'b1, 1'b1);
    Ain = 8'd1; Bin = 8'd2; vin = 1'b1; clr_in = 1'b0; sgn_in = 1'b1;
    WrEn = 1'b1; Cin = 16'd100;
    tick();
    WrEn = 1'b0;
    expc(cyc, 16'd100, 1'b0, 16'd100, 1'b0);
    expc(cyc + 1, 16'd102, 1'b0, 16'd102, 1'b0);
    idle(3);

    // Reset with two valids in flight
    send(8'd3, 8'd3, 1'b1, 1'b1);
    send(8'd3, 8'd3, 1'b0, 1'b1);
    expc(cyc, 16'd9, 1'b0, 16'd9, 1'b0);
    vin = 1'b0; clr_in = 1'b0; Ain = '0; Bin = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expc(cyc, 16'd0, 1'b0, 16'd0, 1'b0);
    for (int k = 4; k <= 8; k++) push(cyc, k, 16'd0);
    ->rst_chk_ev;
    tick();
    rst_n = 1'b1;
    expc(cyc + 1, 16'd0, 1'b0, 16'd0, 1'b0);
    expc(cyc + 2, 16'd0, 1'b0, 16'd0, 1'b0);
    push(cyc + 2, 5, 16'd0);
    idle(4);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
